// File: rtl/regfile_mp.sv
// regfile_mp: parameterised multi-read-port register file with busy scoreboard.
// Reads are combinational. Writes and busy-set take effect at the clock edge.
// An optional hardwired zero register is selected by ZERO_REG.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.

// One read port: a mux over the register array, with the zero-register and
// out-of-range rules applied (and write-through forwarding when enabled).
module regfile_mp_rdport #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DEPTH-1:0][DATA_W-1:0] regs,
    input  logic [DEPTH-1:0]             busy,
`ifdef REGFILE_BYPASS_EN
    input  logic                         fwdEn,
    input  logic [ADDR_W-1:0]            fwdAddr,
    input  logic [DATA_W-1:0]            fwdData,
    input  logic                         fwdBusy,
`endif
    output logic [DATA_W-1:0]            data,
    output logic                         dataBusy
);
    // Select by compare so out-of-range addresses fall through to zero
    always_comb begin
        data     = '0;
        dataBusy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0)) begin
                data     = regs[i];
                dataBusy = busy[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        // fwdEn is only high for valid write addresses, so precedence holds
        if (fwdEn && addr == fwdAddr) begin
            data     = fwdData;
            dataBusy = fwdBusy;
        end
`endif
    end
endmodule

module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     busy_set,
    input  logic [ADDR_W-1:0]        busy_addr,
    output logic                     any_busy
);
    if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : gBadDepth
        $error("regfile_mp: DEPTH out of range");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : gBadNumRd
        $error("regfile_mp: NUM_RD out of range");
    end

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             busy;
    logic [DEPTH-1:0]             busyNext;
    logic                         wrValid;
    logic                         setValid;

    // Address validity: below DEPTH and not the hardwired zero register
    always_comb begin
        wrValid  = wr_en    && ({1'b0, wr_addr}   < (ADDR_W+1)'(DEPTH))
                            && !(ZERO_REG != 0 && wr_addr == '0);
        setValid = busy_set && ({1'b0, busy_addr} < (ADDR_W+1)'(DEPTH))
                            && !(ZERO_REG != 0 && busy_addr == '0);
    end

    // Next busy vector: write clears, then set wins for a newer producer
    always_comb begin
        busyNext = busy;
        for (int i = 0; i < DEPTH; i++) begin
            if (wrValid && wr_addr == ADDR_W'(i))
                busyNext[i] = 1'b0;
            if (setValid && busy_addr == ADDR_W'(i))
                busyNext[i] = 1'b1;
        end
    end

    // Register storage, busy bits and registered any_busy; reset wins
    always_ff @(posedge clk) begin
        if (reset) begin
            regs     <= '0;
            busy     <= '0;
            any_busy <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wrValid && wr_addr == ADDR_W'(i))
                    regs[i] <= wr_data;
            end
            busy     <= busyNext;
            any_busy <= |busyNext;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwdBusy;
    always_comb fwdBusy = setValid && busy_addr == wr_addr;
`endif

    for (genvar k = 0; k < NUM_RD; k++) begin : gRd
        regfile_mp_rdport #(
            .DATA_W  (DATA_W),
            .DEPTH   (DEPTH),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) uPort (
            .addr    (rd_addr[k*ADDR_W +: ADDR_W]),
            .regs    (regs),
            .busy    (busy),
`ifdef REGFILE_BYPASS_EN
            .fwdEn   (wrValid),
            .fwdAddr (wr_addr),
            .fwdData (wr_data),
            .fwdBusy (fwdBusy),
`endif
            .data    (rd_data[k*DATA_W +: DATA_W]),
            .dataBusy(rd_busy[k])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector table plus hand sequences for regfile_mp.
// Three instances share stimulus: default, ZERO_REG=0, and DEPTH=24.
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [NR*AW-1:0] rdAddr;
    logic [NR*DW-1:0] rdData, rdDataZ, rdDataD;
    logic [NR-1:0]    rdBusy, rdBusyZ, rdBusyD;
    logic             wrEn, busySet;
    logic [AW-1:0]    wrAddr, busyAddr;
    logic [DW-1:0]    wrData;
    logic             anyBusy, anyBusyZ, anyBusyD;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk(clk), .reset(reset), .rd_addr(rdAddr), .rd_data(rdData), .rd_busy(rdBusy),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .busy_set(busySet), .busy_addr(busyAddr), .any_busy(anyBusy));

    regfile_mp #(.ZERO_REG(0)) dutZ (
        .clk(clk), .reset(reset), .rd_addr(rdAddr), .rd_data(rdDataZ), .rd_busy(rdBusyZ),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .busy_set(busySet), .busy_addr(busyAddr), .any_busy(anyBusyZ));

    regfile_mp #(.DEPTH(24)) dutD (
        .clk(clk), .reset(reset), .rd_addr(rdAddr), .rd_data(rdDataD), .rd_busy(rdBusyD),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .busy_set(busySet), .busy_addr(busyAddr), .any_busy(anyBusyD));

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          bs;
        logic [AW-1:0] ba;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic          b0, b1, any;
    } vec_t;

    vec_t vecs[13];
    int total  = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Apply one cycle of inputs at the falling edge; reads settle 1ns later
    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic bs, input logic [AW-1:0] ba,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        @(negedge clk);
        reset = 1'b0;
        wrEn = we; wrAddr = wa; wrData = wd;
        busySet = bs; busyAddr = ba;
        rdAddr = {a1, a0};
        #1;
    endtask

    task automatic idle(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        drive(1'b0, '0, '0, 1'b0, '0, a0, a1);
    endtask

    function automatic logic [DW-1:0] expD24(input int i);
        case (i)
            3:       return 32'h77;
            5:       return 32'hDEADBEEF;
            7:       return 32'h1;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        //         we  wa  wd             bs  ba  a0  a1  d0             d1             b0 b1 any
        vecs[0]  = '{1, 5, 32'hDEADBEEF,  0,  0,  1,  2,  32'h0,         32'h0,         0, 0, 0};
        vecs[1]  = '{0, 0, 32'h0,         0,  0,  5,  5,  32'hDEADBEEF,  32'hDEADBEEF,  0, 0, 0};
        vecs[2]  = '{1, 0, 32'h12345678,  1,  0,  5,  0,  32'hDEADBEEF,  32'h0,         0, 0, 0};
        vecs[3]  = '{0, 0, 32'h0,         1,  7,  0,  5,  32'h0,         32'hDEADBEEF,  0, 0, 0};
        vecs[4]  = '{0, 0, 32'h0,         0,  0,  7,  7,  32'h0,         32'h0,         1, 1, 1};
        vecs[5]  = '{1, 7, 32'h55,        0,  0,  5,  0,  32'hDEADBEEF,  32'h0,         0, 0, 1};
        vecs[6]  = '{0, 0, 32'h0,         0,  0,  7,  7,  32'h55,        32'h55,        0, 0, 0};
        vecs[7]  = '{1, 7, 32'hAA,        1,  7,  5,  1,  32'hDEADBEEF,  32'h0,         0, 0, 0};
        vecs[8]  = '{0, 0, 32'h0,         0,  0,  7,  7,  32'hAA,        32'hAA,        1, 1, 1};
        vecs[9]  = '{1, 7, 32'h1,         1,  3,  3,  5,  32'h0,         32'hDEADBEEF,  0, 0, 1};
        vecs[10] = '{0, 0, 32'h0,         0,  0,  3,  7,  32'h0,         32'h1,         1, 0, 1};
        vecs[11] = '{1, 3, 32'h77,        0,  0,  31, 9,  32'h0,         32'h0,         0, 0, 1};
        vecs[12] = '{0, 0, 32'h0,         0,  0,  3,  31, 32'h77,        32'h0,         0, 0, 0};

        // Reset with idle inputs
        reset = 1'b1; wrEn = 0; wrAddr = '0; wrData = '0;
        busySet = 0; busyAddr = '0; rdAddr = '0;
        repeat (2) @(posedge clk);

        // Everything reads zero after reset
        for (int i = 0; i < 32; i++) begin
            idle(AW'(i), AW'(31 - i));
            chk("rst_d0", rdData[31:0], 32'h0);
            chk("rst_d1", rdData[63:32], 32'h0);
            chk("rst_b0", {31'b0, rdBusy[0]}, 32'h0);
            chk("rst_b1", {31'b0, rdBusy[1]}, 32'h0);
            chk("rst_any", {31'b0, anyBusy}, 32'h0);
        end

        // Main vector table against the default instance
        for (int v = 0; v < 13; v++) begin
            drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].bs, vecs[v].ba, vecs[v].a0, vecs[v].a1);
            chk($sformatf("v%0d_d0", v), rdData[31:0], vecs[v].d0);
            chk($sformatf("v%0d_d1", v), rdData[63:32], vecs[v].d1);
            chk($sformatf("v%0d_b0", v), {31'b0, rdBusy[0]}, {31'b0, vecs[v].b0});
            chk($sformatf("v%0d_b1", v), {31'b0, rdBusy[1]}, {31'b0, vecs[v].b1});
            chk($sformatf("v%0d_any", v), {31'b0, anyBusy}, {31'b0, vecs[v].any});
        end

        // ZERO_REG=0: r0 is ordinary storage and kept its busy-set
        idle(0, 0);
        chk("z1_r0", rdData[31:0], 32'h0);
        chk("z0_r0", rdDataZ[31:0], 32'h12345678);
        chk("z0_b0", {31'b0, rdBusyZ[0]}, 32'h1);
        chk("z0_any", {31'b0, anyBusyZ}, 32'h1);

        // DEPTH=24: r30 write and busy-set are ignored there, valid in DEPTH=32
        drive(1'b1, 30, 32'h99, 1'b1, 30, 1, 1);
        idle(30, 30);
        chk("d24_r30", rdDataD[31:0], 32'h0);
        chk("d24_b30", {31'b0, rdBusyD[0]}, 32'h0);
        chk("d24_any", {31'b0, anyBusyD}, 32'h0);
        chk("d32_r30", rdData[31:0], 32'h99);
        chk("d32_b30", {31'b0, rdBusy[0]}, 32'h1);
        for (int i = 0; i < 24; i++) begin
            idle(AW'(i), AW'(i));
            chk($sformatf("d24_r%0d", i), rdDataD[31:0], expD24(i));
        end

        // Same-cycle read of a register being written
        drive(1'b1, 5, 32'hCAFEF00D, 1'b0, 0, 5, 5);
        chk("byp_d0", rdData[31:0], BYP ? 32'hCAFEF00D : 32'hDEADBEEF);
        chk("byp_d1", rdData[63:32], BYP ? 32'hCAFEF00D : 32'hDEADBEEF);
        chk("byp_b0", {31'b0, rdBusy[0]}, 32'h0);
        drive(1'b1, 9, 32'h33, 1'b1, 9, 9, 5);
        chk("bypset_d0", rdData[31:0], BYP ? 32'h33 : 32'h0);
        chk("bypset_b0", {31'b0, rdBusy[0]}, BYP ? 32'h1 : 32'h0);
        chk("bypset_d1", rdData[63:32], 32'hCAFEF00D);
        idle(5, 9);
        chk("post_r5", rdData[31:0], 32'hCAFEF00D);
        chk("post_r9", rdData[63:32], 32'h33);
        chk("post_b9", {31'b0, rdBusy[1]}, 32'h1);

        // Reset mid-sequence discards pending state and beats a write/set
        drive(1'b1, 9, 32'h1, 1'b1, 3, 1, 1);
        @(negedge clk);
        reset = 1'b1; wrEn = 1'b1; wrAddr = 4; wrData = 32'h44;
        busySet = 1'b1; busyAddr = 4;
        idle(9, 4);
        chk("mid_r9", rdData[31:0], 32'h0);
        chk("mid_r4", rdData[63:32], 32'h0);
        chk("mid_b9", {31'b0, rdBusy[0]}, 32'h0);
        chk("mid_b4", {31'b0, rdBusy[1]}, 32'h0);
        chk("mid_any", {31'b0, anyBusy}, 32'h0);
        drive(1'b1, 3, 32'h2, 1'b0, 0, 1, 1);
        idle(3, 30);
        chk("mid_r3", rdData[31:0], 32'h2);
        chk("mid_r30", rdData[63:32], 32'h0);
        chk("mid_b3", {31'b0, rdBusy[0]}, 32'h0);
        chk("mid_any2", {31'b0, anyBusy}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
